// File: rtl/matrix_col_reader.sv
// Walks one column of a row-major MAT_N x MAT_N matrix in memory and streams it over valid/ready.
// Two cycles minimum per element (FETCH then PRESENT); PRESENT stalls for as long as out_ready is low.
module matrix_col_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int MEM_DEPTH = 100,
    parameter int MAT_N     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] col_idx,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    localparam int XW = ADDR_W + 2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] row;
    logic [XW-1:0]     last_addr;
    logic              range_ok;

    // Address of the bottom element of the column, computed wide so it cannot wrap.
    assign last_addr = {2'b00, base_addr} + XW'((MAT_N - 1) * MAT_N) + {2'b00, col_idx};
    assign range_ok  = (col_idx < ADDR_W'(MAT_N)) && (last_addr <= XW'(MEM_DEPTH - 1));

    assign busy   = (state != S_IDLE);
    assign mem_WE = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            row       <= '0;
            mem_A     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            mem_A <= base_addr + col_idx;
                            row   <= '0;
                            state <= S_FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    out_last  <= (row == ADDR_W'(MAT_N - 1));
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            row   <= row + ADDR_W'(1);
                            mem_A <= mem_A + ADDR_W'(MAT_N);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
